instr_aligner: RTL and testbench
================================

INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset (synchronous, active-low).
REQ-002 SHALL have port stall_i input 1: hazard-unit stall; no instruction consumed while high.
REQ-003 SHALL have ports redirect_i input 1 (taken branch/jump) and redirect_pc_i input 32 (target, bit 0 always 0).
REQ-004 SHALL have ports imem_req_o output 1 and imem_addr_o output 32: fetch request, word-aligned address.
REQ-005 SHALL have ports imem_valid_i input 1 and imem_rdata_i input 32: response for the single outstanding request, arriving 1 or more cycles after issue.
REQ-006 SHALL have ports instr_o output 32, PC_o output 32, compress_o output 1 and valid_o output 1, feeding the IF/ID register.

Function
REQ-007 SHALL hold a 4-halfword FIFO buffer with count 0..4, a fetch address fetch_pc, an instruction address cur_pc, and flags outstanding and discard.
REQ-008 SHALL classify the head halfword: bits[1:0] != 2'b11 means compressed (needs 1 halfword), otherwise 32-bit (needs 2 halfwords).
REQ-009 SHALL assert valid_o combinationally when the buffer holds the halfwords needed for the head instruction.
REQ-010 When valid_o and compressed: instr_o = {16'b0, head}, compress_o = 1, PC_o = cur_pc.
REQ-011 When valid_o and 32-bit: instr_o = {second, head}, compress_o = 0, PC_o = cur_pc.
REQ-012 When valid_o = 0: instr_o = 32'h00000013 (NOP), compress_o = 0, PC_o = cur_pc.
REQ-013 SHALL consume the head instruction on a clock edge with valid_o = 1, stall_i = 0 and redirect_i = 0: pop 1 or 2 halfwords; cur_pc += 2 or 4 (mod 2^32).
REQ-014 SHALL assert imem_req_o = (count <= 2) and !outstanding and !redirect_i, with imem_addr_o = fetch_pc.
REQ-015 A request is accepted in the cycle imem_req_o = 1: set outstanding, fetch_pc += 4 (wraps at 2^32).
REQ-016 On imem_valid_i with outstanding and !discard: push the low halfword, then the high halfword, and clear outstanding.
REQ-017 If a drop_low flag is set on the push in REQ-016, only the high halfword is pushed and drop_low is cleared.
REQ-018 Push and consume in the same cycle SHALL both take effect: count_next = count - popped + pushed, never above 4.
REQ-019 On imem_valid_i with discard set: drop the data and clear outstanding and discard.
REQ-020 On redirect_i:
- flush the buffer (count = 0) and set cur_pc = redirect_pc_i;
- set fetch_pc = {redirect_pc_i[31:2], 2'b00} and drop_low = redirect_pc_i[1];
- if outstanding and imem_valid_i = 0 in that cycle, set discard;
- no consume and no request in that cycle.
REQ-021 redirect_i SHALL take priority over stall_i, consume and push in the same cycle.
REQ-022 imem_valid_i without outstanding SHALL be ignored.
REQ-023 A 32-bit instruction straddling two words SHALL be output only after both halves are buffered; valid_o is 0 meanwhile.

Reset
REQ-024 While rst_n = 0 at a clock edge, the block SHALL reset:
- count = 0, outstanding = 0, discard = 0, drop_low = 0;
- fetch_pc = 0 and cur_pc = 0.
REQ-025 Outputs following reset SHALL be: valid_o = 0, instr_o = 32'h00000013, compress_o = 0, PC_o = 0, imem_req_o = 0 during reset.
REQ-026 Reset during an outstanding request SHALL discard the later response: outstanding = 0, and REQ-022 drops the data.

Verification
REQ-027 After reset, memory returns 32'h00A00093 for address 0 -> valid_o = 1, instr_o = 32'h00A00093, PC_o = 0, compress_o = 0; the next request is to address 4.
REQ-028 Word 32'h45014505 at address 0 -> two compressed outputs: instr_o = 32'h00004505 at PC 0, then 32'h00004501 at PC 2.
REQ-029 Straddle case: word0 = 32'h00934505, word1 = 32'hXXXX0050:
- compressed output 32'h00004505 at PC 0;
- then valid_o = 0 until word1 arrives;
- then instr_o = 32'h00500093 at PC 2.
REQ-030 Redirect to 32'h00000102 with a fetch outstanding:
- the stale response is dropped;
- the next request is to address 32'h00000100;
- its low halfword is discarded and the first output has PC_o = 32'h00000102.
REQ-031 stall_i held high 3 cycles with a full buffer -> instr_o and PC_o are unchanged, no request is issued, and count stays 4.
REQ-032 rst_n low for 1 cycle mid-stream -> all outputs reach their reset values, and the first request after release is to address 0.

Source files
------------

// File: rtl/instr_aligner_if.sv
// Bundles the instruction aligner's datapath signals.
//
// Signals:
//   stall_i       - hazard stall; the head instruction is held while high
//   redirect_i    - taken branch/jump; flushes and restarts fetch
//   redirect_pc_i - redirect target (halfword aligned)
//   imem_req_o    - fetch request strobe, accepted in the cycle it is high
//   imem_addr_o   - word-aligned fetch address
//   imem_valid_i  - response strobe for the single outstanding request
//   imem_rdata_i  - response data word
//   instr_o       - aligned instruction (NOP when nothing is available)
//   PC_o          - address of the instruction on instr_o
//   compress_o    - instr_o holds a 16-bit instruction in its low half
//   valid_o       - instr_o/PC_o/compress_o describe a complete instruction
//
// Modports: slave = the aligner, master = the fetch/decode environment.
interface instr_aligner_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] PC_o;
    logic        compress_o;
    logic        valid_o;

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, imem_valid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, instr_o, PC_o, compress_o, valid_o
    );

    modport master (
        output stall_i, redirect_i, redirect_pc_i, imem_valid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, instr_o, PC_o, compress_o, valid_o
    );
endinterface

// File: rtl/instr_aligner.sv
// Instruction aligner for a fetch unit supporting 16-bit compressed and
// 32-bit instructions. Word-sized fetch responses are split into halfwords
// and kept in a 4-entry FIFO; the head of the FIFO is presented as one
// complete instruction per cycle to the IF/ID register.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous, active-low reset
//   bus   - instr_aligner_if.slave (stall/redirect in, imem request and
//           response, aligned instruction out)
module instr_aligner (
    input  logic             clk,
    input  logic             rst_n,
    instr_aligner_if.slave   bus
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Halfword FIFO, slot 0 is the head.
    logic [3:0][15:0] buf_reg;
    logic [3:0][15:0] buf_next;
    logic [2:0]       count_reg, count_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [31:0]      cur_pc_reg, cur_pc_next;
    logic             outstanding_reg, outstanding_next;
    logic             discard_reg, discard_next;
    logic             drop_low_reg, drop_low_next;

    logic [15:0] head_hw;
    logic [15:0] second_hw;
    logic        head_is_c;
    logic [2:0]  need_cnt;
    logic        out_valid;
    logic        consume;
    logic [2:0]  pop_cnt;
    logic [2:0]  keep_cnt;
    logic        req;
    logic        resp_take;
    logic [2:0]  push_cnt;
    logic [15:0] push_hw0;
    logic [15:0] push_hw1;

    assign head_hw   = buf_reg[0];
    assign second_hw = buf_reg[1];
    assign head_is_c = (head_hw[1:0] != 2'b11);
    assign need_cnt  = head_is_c ? 3'd1 : 3'd2;
    assign out_valid = (count_reg >= need_cnt);

    // A redirect wins over everything: no consume, no request, no push.
    assign consume  = out_valid && !bus.stall_i && !bus.redirect_i;
    assign pop_cnt  = consume ? need_cnt : 3'd0;
    assign keep_cnt = count_reg - pop_cnt;

    // Gated by rst_n so no request escapes while reset is held.
    assign req = rst_n && (count_reg <= 3'd2) && !outstanding_reg && !bus.redirect_i;

    // A request is only issued with at most 2 halfwords buffered and only one
    // is ever in flight, so a push can never overflow the 4 slots.
    assign resp_take = bus.imem_valid_i && outstanding_reg && !discard_reg && !bus.redirect_i;
    assign push_cnt  = resp_take ? (drop_low_reg ? 3'd1 : 3'd2) : 3'd0;
    // After a redirect to an odd halfword, the low half of the first word
    // lies before the target and is skipped.
    assign push_hw0  = drop_low_reg ? bus.imem_rdata_i[31:16] : bus.imem_rdata_i[15:0];
    assign push_hw1  = bus.imem_rdata_i[31:16];

    // Per-slot next value: survivors shift down by the popped amount, new
    // halfwords land right behind the survivors.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        localparam logic [2:0] SLOT = 3'(gi);
        logic [1:0] src_idx;
        assign src_idx = 2'(SLOT + pop_cnt);
        assign buf_next[gi] = (SLOT < keep_cnt)                                  ? buf_reg[src_idx] :
                              (push_cnt != 3'd0 && SLOT == keep_cnt)             ? push_hw0 :
                              (push_cnt == 3'd2 && SLOT == keep_cnt + 3'd1)      ? push_hw1 :
                                                                                   buf_reg[gi];
    end

    always_comb begin
        count_next       = keep_cnt + push_cnt;
        fetch_pc_next    = fetch_pc_reg;
        cur_pc_next      = cur_pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        drop_low_next    = drop_low_reg;

        if (bus.redirect_i) begin
            count_next    = 3'd0;
            cur_pc_next   = bus.redirect_pc_i;
            fetch_pc_next = {bus.redirect_pc_i[31:2], 2'b00};
            drop_low_next = bus.redirect_pc_i[1];
            if (outstanding_reg) begin
                if (bus.imem_valid_i) begin
                    // Response arrives in the redirect cycle: simply dropped.
                    outstanding_next = 1'b0;
                    discard_next     = 1'b0;
                end else begin
                    // Still in flight: remember to throw it away on arrival.
                    discard_next = 1'b1;
                end
            end
        end else begin
            if (consume) begin
                cur_pc_next = cur_pc_reg + (head_is_c ? 32'd2 : 32'd4);
            end
            if (req) begin
                outstanding_next = 1'b1;
                fetch_pc_next    = fetch_pc_reg + 32'd4;
            end
            if (bus.imem_valid_i && outstanding_reg) begin
                outstanding_next = 1'b0;
                discard_next     = 1'b0;
                if (!discard_reg) begin
                    drop_low_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg       <= 3'd0;
            fetch_pc_reg    <= 32'd0;
            cur_pc_reg      <= 32'd0;
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
            drop_low_reg    <= 1'b0;
        end else begin
            count_reg       <= count_next;
            fetch_pc_reg    <= fetch_pc_next;
            cur_pc_reg      <= cur_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            drop_low_reg    <= drop_low_next;
        end
    end

    // Buffer contents are qualified by count_reg, so no reset is needed.
    always_ff @(posedge clk) begin
        buf_reg <= buf_next;
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = fetch_pc_reg;
    assign bus.valid_o     = out_valid;
    assign bus.compress_o  = out_valid && head_is_c;
    assign bus.PC_o        = cur_pc_reg;
    assign bus.instr_o     = !out_valid ? NOP_INSTR :
                             head_is_c  ? {16'h0000, head_hw} :
                                          {second_hw, head_hw};

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench for instr_aligner: a table-driven instruction stream
// plus hand-written multi-cycle sequences (full-buffer stall, straddling
// instruction, redirect with a fetch in flight, mid-stream reset). A small
// memory model answers fetch requests with a programmable latency; expected
// outputs are queued and compared whenever the DUT consumes an instruction.
module tb_instr_aligner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_aligner_if bus ();

    instr_aligner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] enc;
        logic        is16;
        int          lat;
        int          stall_cyc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_comp;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] mem[bit [31:0]];

    // Memory model state
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;
    int          mem_lat = 1;

    // Output snapshot of the most recent cycle
    logic        s_req, s_valid, s_comp;
    logic [31:0] s_addr, s_instr, s_pc;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0001_0001;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic expect_out(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive the memory response, sample outputs just after
    // the inputs settle (well before the rising edge), then advance to the
    // next falling edge.
    task automatic cycle();
        exp_t e;
        bus.imem_valid_i = 1'b0;
        bus.imem_rdata_i = 32'h0;
        if (pend) begin
            if (pend_wait <= 1) begin
                bus.imem_valid_i = 1'b1;
                bus.imem_rdata_i = mem_rd(pend_addr);
                pend = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        #1;
        s_req   = bus.imem_req_o;
        s_addr  = bus.imem_addr_o;
        s_valid = bus.valid_o;
        s_instr = bus.instr_o;
        s_pc    = bus.PC_o;
        s_comp  = bus.compress_o;
        if (rst_n && s_valid && !bus.stall_i && !bus.redirect_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %08h at pc %08h, expected none", s_instr, s_pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_instr", s_instr, e.instr);
                chk("out_pc", s_pc, e.pc);
                chk("out_comp", 32'(s_comp), 32'(e.comp));
                $display("consume pc=%08h instr=%08h comp=%0d", s_pc, s_instr, s_comp);
            end
        end
        if (s_req) begin
            chk("req_while_busy", 32'(pend), 32'd0);
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_wait = mem_lat;
            req_log.push_back(s_addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d outputs pending, expected 0 after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        pend             = 1'b0;
        rst_n            = 1'b0;
        bus.stall_i      = 1'b0;
        bus.redirect_i   = 1'b0;
        bus.redirect_pc_i = 32'h0;
        cycle();
        cycle();
        rst_n = 1'b1;
        req_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hw_q[$];

        // Instruction stream starting at address 0.
        vecs[0]  = '{32'h00A00093, 1'b0, 1, 0, 32'h00A00093, 32'h00, 1'b0};
        vecs[1]  = '{32'h00004505, 1'b1, 2, 0, 32'h00004505, 32'h04, 1'b1};
        vecs[2]  = '{32'h00004501, 1'b1, 1, 2, 32'h00004501, 32'h06, 1'b1};
        vecs[3]  = '{32'h00500113, 1'b0, 3, 0, 32'h00500113, 32'h08, 1'b0};
        vecs[4]  = '{32'h00000505, 1'b1, 1, 0, 32'h00000505, 32'h0C, 1'b1};
        vecs[5]  = '{32'h002081B3, 1'b0, 2, 1, 32'h002081B3, 32'h0E, 1'b0};
        vecs[6]  = '{32'h00008082, 1'b1, 1, 0, 32'h00008082, 32'h12, 1'b1};
        vecs[7]  = '{32'h00004585, 1'b1, 3, 3, 32'h00004585, 32'h14, 1'b1};
        vecs[8]  = '{32'h00B50633, 1'b0, 1, 0, 32'h00B50633, 32'h16, 1'b0};
        vecs[9]  = '{32'hFFF00713, 1'b0, 2, 0, 32'hFFF00713, 32'h1A, 1'b0};
        vecs[10] = '{32'h00000001, 1'b1, 1, 2, 32'h00000001, 32'h1E, 1'b1};
        vecs[11] = '{32'h1234567B, 1'b0, 3, 0, 32'h1234567B, 32'h20, 1'b0};

        foreach (vecs[i]) begin
            hw_q.push_back(vecs[i].enc[15:0]);
            if (!vecs[i].is16) hw_q.push_back(vecs[i].enc[31:16]);
        end
        if (hw_q.size() % 2 != 0) hw_q.push_back(16'h0001);
        for (int k = 0; k < hw_q.size() / 2; k++) begin
            mem[32'(4 * k)] = {hw_q[2 * k + 1], hw_q[2 * k]};
        end
        mem[32'h200] = 32'h00934505;
        mem[32'h204] = 32'hABCD0050;
        mem[32'h100] = 32'h4585BEEF;
        mem[32'h104] = 32'h45014505;
        mem[32'hFF0] = 32'hDEADBEEF;

        bus.imem_valid_i = 1'b0;
        bus.imem_rdata_i = 32'h0;

        // Reset state
        do_reset();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_instr", s_instr, NOP);
        chk("rst_pc", s_pc, 32'd0);
        chk("rst_comp", 32'(s_comp), 32'd0);

        // Table-driven stream
        for (int i = 0; i < 12; i++) begin
            expect_out(vecs[i].exp_instr, vecs[i].exp_pc, vecs[i].exp_comp);
            mem_lat = vecs[i].lat;
            bus.stall_i = 1'b1;
            for (int s = 0; s < vecs[i].stall_cyc; s++) cycle();
            bus.stall_i = 1'b0;
            drain(40);
            if (i == 0) begin
                chk("first_req_addr", req_at(0), 32'h0);
                chk("second_req_addr", req_at(1), 32'h4);
            end
        end
        bus.stall_i = 1'b1;

        // Stall with a full buffer
        do_reset();
        bus.stall_i = 1'b1;
        mem_lat = 1;
        repeat (5) cycle();
        chk("full_valid", 32'(s_valid), 32'd1);
        chk("full_instr", s_instr, 32'h00A00093);
        chk("full_pc", s_pc, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_instr", s_instr, 32'h00A00093);
            chk("stall_pc", s_pc, 32'h0);
            chk("stall_req", 32'(s_req), 32'd0);
        end
        chk("stall_req_count", 32'(req_log.size()), 32'd2);
        expect_out(32'h00A00093, 32'h0, 1'b0);
        expect_out(32'h00004505, 32'h4, 1'b1);
        bus.stall_i = 1'b0;
        drain(10);
        bus.stall_i = 1'b1;

        // Straddling 32-bit instruction
        do_reset();
        mem_lat = 5;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        cycle();
        bus.redirect_i = 1'b0;
        expect_out(32'h00004505, 32'h200, 1'b1);
        drain(20);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("straddle_wait_valid", 32'(s_valid), 32'd0);
            chk("straddle_wait_instr", s_instr, NOP);
        end
        expect_out(32'h00500093, 32'h202, 1'b0);
        drain(20);
        bus.stall_i = 1'b1;

        // Redirect with a fetch in flight
        do_reset();
        mem_lat = 4;
        cycle();
        chk("pre_redirect_req", req_at(0), 32'h0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h102;
        cycle();
        bus.redirect_i = 1'b0;
        req_log.delete();
        expect_out(32'h00004585, 32'h102, 1'b1);
        expect_out(32'h00004505, 32'h104, 1'b1);
        expect_out(32'h00004501, 32'h106, 1'b1);
        drain(60);
        chk("redirect_req_addr", req_at(0), 32'h100);
        bus.stall_i = 1'b1;

        // One-cycle reset mid-stream, with a stale response right after it
        mem_lat = 3;
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("midrst_req", 32'(s_req), 32'd0);
        rst_n = 1'b1;
        bus.stall_i = 1'b0;
        pend      = 1'b1;
        pend_addr = 32'hFF0;
        pend_wait = 1;
        req_log.delete();
        expect_out(32'h00A00093, 32'h0, 1'b0);
        expect_out(32'h00004505, 32'h4, 1'b1);
        cycle();
        chk("midrst_valid", 32'(s_valid), 32'd0);
        chk("midrst_instr", s_instr, NOP);
        chk("midrst_pc", s_pc, 32'h0);
        chk("midrst_comp", 32'(s_comp), 32'd0);
        chk("midrst_req_addr", req_at(0), 32'h0);
        drain(30);
        bus.stall_i = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
